// File: rtl/mda_adc_responder.sv
// Serial ADC responder: converts on convst, returns the selected 12-bit channel
// over sck/sdo and captures a 6-bit config word from sdi for the next conversion.
module mda_adc_responder #(
  parameter int CONV_CYCLES = 80
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_convst,
  input  logic        i_sck,
  input  logic        i_sdi,
  output logic        o_sdo,
  input  logic [95:0] i_ch_data,
  output logic        o_busy,
  output logic [5:0]  o_cfg,
  output logic        o_frame_done,
  output logic        o_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  localparam logic [7:0]  LP_CONV_LOAD = 8'(CONV_CYCLES - 1);
  localparam logic [5:0]  LP_CFG_RST   = 6'b100010;
  localparam logic [3:0]  LP_FRAME_LEN = 4'd12;
  localparam logic [3:0]  LP_CFG_LEN   = 4'd6;

  function automatic logic [11:0] sel_channel(input logic [95:0] data, input logic [2:0] ch);
    logic [11:0] v;
    case (ch)
      3'd0:    v = data[11:0];
      3'd1:    v = data[23:12];
      3'd2:    v = data[35:24];
      3'd3:    v = data[47:36];
      3'd4:    v = data[59:48];
      3'd5:    v = data[71:60];
      3'd6:    v = data[83:72];
      3'd7:    v = data[95:84];
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_convst_s1, r_convst_s2, r_convst_d;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_sdi_s1, r_sdi_s2;
  logic [7:0]  r_conv_cnt, w_conv_cnt_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [5:0]  r_shift, w_shift_nxt;
  logic [11:0] r_sample, w_sample_nxt;
  logic [5:0]  r_cfg, w_cfg_nxt;
  logic        r_sdo, w_sdo_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic        r_err, w_err_nxt;

  logic        w_convst_rise, w_sck_rise, w_sck_fall;
  logic [2:0]  w_ch;
  logic [11:0] w_raw, w_new_sample;

  assign w_convst_rise = r_convst_s2 & ~r_convst_d;
  assign w_sck_rise    = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall    = ~r_sck_s2 & r_sck_d;
  // Channel select is {S1, S0, O/S}; UNI=0 converts offset-binary to two's complement.
  assign w_ch          = {r_cfg[3], r_cfg[2], r_cfg[4]};
  assign w_raw         = sel_channel(i_ch_data, w_ch);
  assign w_new_sample  = r_cfg[1] ? w_raw : (w_raw ^ 12'h800);

  assign o_sdo        = r_sdo;
  assign o_busy       = r_busy;
  assign o_cfg        = r_cfg;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

  // State register, synchronizers and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_convst_s1  <= 1'b0;
      r_convst_s2  <= 1'b0;
      r_convst_d   <= 1'b0;
      r_sck_s1     <= 1'b0;
      r_sck_s2     <= 1'b0;
      r_sck_d      <= 1'b0;
      r_sdi_s1     <= 1'b0;
      r_sdi_s2     <= 1'b0;
      r_conv_cnt   <= 8'd0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 6'd0;
      r_sample     <= 12'd0;
      r_cfg        <= LP_CFG_RST;
      r_sdo        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_convst_s1  <= i_convst;
      r_convst_s2  <= r_convst_s1;
      r_convst_d   <= r_convst_s2;
      r_sck_s1     <= i_sck;
      r_sck_s2     <= r_sck_s1;
      r_sck_d      <= r_sck_s2;
      r_sdi_s1     <= i_sdi;
      r_sdi_s2     <= r_sdi_s1;
      r_conv_cnt   <= w_conv_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_sample     <= w_sample_nxt;
      r_cfg        <= w_cfg_nxt;
      r_sdo        <= w_sdo_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_conv_cnt_nxt   = r_conv_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_sample_nxt     = r_sample;
    w_cfg_nxt        = r_cfg;
    w_sdo_nxt        = r_sdo;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_sdo_nxt = 1'b0;
        if (w_convst_rise) begin
          w_sample_nxt   = w_new_sample;
          w_conv_cnt_nxt = LP_CONV_LOAD;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = ST_CONVERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_CONVERT: begin
        w_sdo_nxt = 1'b0;
        if (w_convst_rise) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b0;
        end
        if (r_conv_cnt == 8'd0) begin
          w_busy_nxt    = 1'b0;
          w_sdo_nxt     = r_sample[11];
          w_bit_cnt_nxt = 4'd0;
          w_state_nxt   = ST_READY;
        end else begin
          w_conv_cnt_nxt = r_conv_cnt - 8'd1;
        end
      end

      ST_READY, ST_SHIFT: begin
        if (w_convst_rise) begin
          // Abort: cfg keeps its old value and a fresh conversion starts now.
          w_err_nxt      = 1'b1;
          w_sample_nxt   = w_new_sample;
          w_conv_cnt_nxt = LP_CONV_LOAD;
          w_busy_nxt     = 1'b1;
          w_sdo_nxt      = 1'b0;
          w_bit_cnt_nxt  = 4'd0;
          w_state_nxt    = ST_CONVERT;
        end else if (w_sck_rise) begin
          if (r_bit_cnt < LP_FRAME_LEN) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            w_state_nxt   = ST_SHIFT;
            if (r_bit_cnt < LP_CFG_LEN) begin
              w_shift_nxt = {r_shift[4:0], r_sdi_s2};
            end else begin
              w_shift_nxt = r_shift;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt;
          end
        end else if (w_sck_fall && (r_state == ST_SHIFT)) begin
          if (r_bit_cnt == LP_FRAME_LEN) begin
            w_cfg_nxt        = r_shift;
            w_frame_done_nxt = 1'b1;
            w_sdo_nxt        = 1'b0;
            w_bit_cnt_nxt    = 4'd0;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_sample_nxt = {r_sample[10:0], 1'b0};
            w_sdo_nxt    = r_sample[10];
          end
        end else begin
          w_state_nxt = r_state;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_sdo_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mda_adc_responder.sv
// Directed bench for mda_adc_responder: stimulus pushes expected frames into a
// queue, a monitor checks them against the captured sdo word on each frame_done.
module tb_mda_adc_responder;

  logic        clk;
  logic        reset;
  logic        convst;
  logic        sck;
  logic        sdi;
  logic        sdo;
  logic [95:0] ch_data;
  logic        busy;
  logic [5:0]  cfg;
  logic        frame_done;
  logic        err;

  typedef struct packed {
    logic [11:0] data;
    logic [5:0]  cfg;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  int          seen_frames;
  int          seen_err;
  int          exp_frames;
  int          exp_err;
  logic [11:0] mon_word;

  mda_adc_responder #(.CONV_CYCLES(80)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_convst    (convst),
    .i_sck       (sck),
    .i_sdi       (sdi),
    .o_sdo       (sdo),
    .i_ch_data   (ch_data),
    .o_busy      (busy),
    .o_cfg       (cfg),
    .o_frame_done(frame_done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // The master reads sdo on its own rising sck edge.
  always @(posedge sck) mon_word = {mon_word[10:0], sdo};

  // Scoreboard monitor: every frame_done pops one expected frame.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      seen_frames++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_data", {20'd0, mon_word}, {20'd0, e.data});
        check("frame_cfg", {26'd0, cfg}, {26'd0, e.cfg});
      end
    end
    if (err === 1'b1) seen_err++;
  end

  task automatic convst_and_wait(input bit mid);
    int cnt;
    bit sdo_seen;
    cnt = 0;
    sdo_seen = 1'b0;
    @(negedge clk);
    convst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 3) convst = 1'b0;
      if (mid && cnt == 40) convst = 1'b1;
      if (mid && cnt == 44) convst = 1'b0;
      if (busy) begin
        cnt++;
        if (sdo) sdo_seen = 1'b1;
      end else if (cnt > 0) begin
        break;
      end
    end
    convst = 1'b0;
    check("busy_len", cnt, 32'd80);
    check("sdo_during_conv", {31'd0, sdo_seen}, 32'd0);
  endtask

  task automatic frame(input logic [5:0] bits, input int nrise);
    for (int i = 0; i < nrise; i++) begin
      @(negedge clk);
      sdi = (i < 6) ? bits[5 - i] : 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
      repeat (6) @(negedge clk);
    end
    sdi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic push_exp(input logic [11:0] d, input logic [5:0] c);
    exp_t e;
    e.data = d;
    e.cfg  = c;
    exp_q.push_back(e);
    exp_frames++;
  endtask

  initial begin
    total = 0; bad = 0; seen_frames = 0; seen_err = 0;
    exp_frames = 0; exp_err = 0; mon_word = 12'd0;
    reset = 1'b1; convst = 1'b0; sck = 1'b0; sdi = 1'b0;
    ch_data = 96'd0;
    ch_data[11:0]  = 12'h123;
    ch_data[71:60] = 12'hABC;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sdo", {31'd0, sdo}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg", {26'd0, cfg}, 32'h22);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Default config: channel 0 unipolar.
    convst_and_wait(1'b0);
    push_exp(12'h123, 6'b100010);
    frame(6'b100010, 12);

    // Config switches to ch5 only for the following conversion.
    convst_and_wait(1'b0);
    push_exp(12'h123, 6'b111010);
    frame(6'b111010, 12);
    convst_and_wait(1'b0);
    push_exp(12'hABC, 6'b111000);
    frame(6'b111000, 12);

    // ch5 bipolar, with a stray convst in the middle of the conversion.
    convst_and_wait(1'b1);
    exp_err++;
    check("err_mid_conv", seen_err, exp_err);
    push_exp(12'h2BC, 6'b100010);
    frame(6'b100010, 12);

    // Abort after 4 sck rises carrying a new config.
    convst_and_wait(1'b0);
    frame(6'b111010, 4);
    convst_and_wait(1'b0);
    exp_err++;
    check("err_abort", seen_err, exp_err);
    check("cfg_after_abort", {26'd0, cfg}, 32'h22);
    check("frames_after_abort", seen_frames, exp_frames);
    push_exp(12'h123, 6'b111000);
    frame(6'b111000, 12);

    // Reset in the middle of a frame.
    convst_and_wait(1'b0);
    frame(6'b100010, 7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sdo", {31'd0, sdo}, 32'd0);
    check("midrst_cfg", {26'd0, cfg}, 32'h22);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    frame(6'b111111, 12);
    check("idle_sck_cfg", {26'd0, cfg}, 32'h22);
    check("idle_sck_sdo", {31'd0, sdo}, 32'd0);
    check("idle_sck_busy", {31'd0, busy}, 32'd0);

    repeat (10) @(negedge clk);
    check("frame_count", seen_frames, exp_frames);
    check("queue_empty", exp_q.size(), 32'd0);
    check("err_count", seen_err, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mda_adc_responder.md
MDA_ADC_RESPONDER -- requirements
Module: mda_adc_responder

Interface
REQ-001 Parameter CONV_CYCLES, default 80, conversion time in clk cycles (1.6 us at 50 MHz); legal range 2..255.
REQ-002 clk  input  1  system clock; single clock domain, all state on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 convst  input  1  conversion start from the ADC master; asynchronous to clk.
REQ-005 sck  input  1  serial clock from the master; asynchronous to clk.
REQ-006 sdi  input  1  serial config data from the master, MSB first.
REQ-007 sdo  output  1  serial result data to the master, MSB first.
REQ-008 ch_data  input  96  eight 12-bit channel values; channel n is bits [12n+11:12n].
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 cfg  output  6  active config word {S/D, O/S, S1, S0, UNI, SLP}.
REQ-011 frame_done  output  1  one-cycle pulse when a complete 12-bit frame finishes.
REQ-012 err  output  1  one-cycle pulse when convst rises mid-conversion or mid-frame.

Function
REQ-013 convst, sck and sdi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized value and its one-cycle-delayed copy.
REQ-014 The state machine SHALL have four states: IDLE, CONVERT, READY and SHIFT.
REQ-015 IDLE, on a convst rising edge: latch the sample, load the counter with CONV_CYCLES-1, set busy=1, go to CONVERT.
REQ-016 The sample SHALL be taken from ch_data on the cycle the convst rising edge is detected, using the channel ch = {S1, S0, O/S} from the current cfg.
REQ-017 The sample SHALL be the raw value when UNI=1, and the raw value XOR 12'h800 when UNI=0.
REQ-018 S/D and SLP SHALL be stored and reflected on cfg but SHALL have no other effect.
REQ-019 CONVERT: decrement the counter each cycle; on the cycle the counter is 0, set busy=0, drive sdo=sample[11], clear the bit counter and go to READY.
REQ-020 READY/SHIFT, on each sck rising edge: bit counter +1; while the count before the increment is less than 6, shift the synchronized sdi into a 6-bit shift register, LSB end. The first sck rising edge moves READY to SHIFT.
REQ-021 SHIFT, on each sck falling edge: shift the sample left by one and drive sdo with the new MSB; from the 12th falling edge onward sdo SHALL be 0.
REQ-022 On the sck falling edge that follows the 12th rising edge:
 - cfg <= shift register;
 - pulse frame_done for 1 cycle;
 - sdo <= 0;
 - go to IDLE.
 A new cfg therefore applies to the next conversion, not the current frame.
REQ-023 sck edges SHALL be ignored in IDLE and CONVERT.
REQ-024 sck edges beyond 12 per frame SHALL be ignored.
REQ-025 A convst rising edge in CONVERT SHALL pulse err and be otherwise ignored; the conversion SHALL continue.
REQ-026 A convst rising edge in READY or SHIFT SHALL:
 - abort the frame, leaving cfg unchanged;
 - pulse err;
 - start a new conversion as in REQ-015, in the same cycle.
REQ-027 sdo SHALL be 0 in IDLE and CONVERT.
REQ-028 A simultaneously detected sck rising and falling edge cannot occur, since sck is a single synchronized bit; at most one edge is detected per cycle.

Reset
REQ-029 On reset: state=IDLE, sdo=0, busy=0, frame_done=0, err=0, cfg=6'b100010 (channel 0, unipolar), counters, sample and shift register cleared, synchronizer flops cleared.
REQ-030 Reset asserted in any state, including mid-shift, SHALL take effect on the next clk edge and discard the in-flight frame.

Verification
REQ-031 After reset, ch_data ch0=12'h123; pulse convst; after the conversion completes, clock 12 sck with sdi=6'b100010 then zeros -> busy high for 80 cycles; sdo bits read 12'h123; one frame_done pulse; cfg stays 6'b100010.
REQ-032 ch5=12'hABC; frame A with sdi=6'b111010 -> frame A returns ch0 data 12'h123, cfg becomes 6'b111010; next frame returns 12'hABC.
REQ-033 cfg=6'b111000 (ch5, bipolar), ch5=12'hABC -> frame returns 12'h2BC.
REQ-034 convst pulsed at cycle 40 of a conversion -> err pulses once; busy still falls at cycle 80; data unchanged.
REQ-035 convst pulsed after 4 sck rising edges of a frame carrying a new config -> err pulses; cfg unchanged; a new conversion starts; no frame_done pulse.
REQ-036 reset asserted after 7 sck edges -> next cycle: IDLE, sdo=0, cfg=6'b100010; subsequent sck edges are ignored.
